// File: rtl/mdr_result_arbiter_pkg.sv
// Shared types and constants for the multiply/divide/root result arbiter.
package mdr_result_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index reached by stepping 'off' places past 'last', wrapping at 'ch'.
    function automatic int unsigned rr_next(input int unsigned last,
                                            input int unsigned off,
                                            input int unsigned ch);
        return (last + off) % ch;
    endfunction

endpackage

// File: rtl/mdr_result_arbiter_rr_grant.sv
// Round-robin search: first valid channel after last_i, wrapping to channel 0.
module mdr_result_arbiter_rr_grant
    import mdr_result_arbiter_pkg::*;
#(
    parameter  int unsigned CH = 3,
    localparam int unsigned SW = $clog2(CH)
) (
    input  logic [CH-1:0] valid_i,
    input  logic [SW-1:0] last_i,
    output logic [SW-1:0] grant_c,
    output logic          found_c
);

    logic [SW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        idx     = '0;
        for (int k = CH; k >= 1; k--) begin
            idx = SW'(rr_next(32'(last_i), 32'(k), CH));
            if (valid_i[idx]) begin
                grant_c = idx;
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdr_result_arbiter.sv
// Selects one result channel per capture opportunity (fixed or round-robin)
// into a single registered output slot with valid/ready handshaking.
module mdr_result_arbiter
    import mdr_result_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned CH = 3,
    localparam int unsigned SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err_sel
);

    localparam int unsigned NPAD = 1 << SW;

    state_e        state_q;
    logic [N-1:0]  out_data_q;
    logic [SW-1:0] out_src_q;
    logic [SW-1:0] last_q;
    logic          err_q;

    logic [N-1:0]  ch_data [CH];
    logic [NPAD-1:0] valid_pad_c;
    logic          cap_c;
    logic          sel_ok_c;
    logic          found_c;
    logic [SW-1:0] grant_c;
    logic          rr_found_c;
    logic [SW-1:0] rr_grant_c;

    for (genvar i = 0; i < CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*N +: N];
    end

    // Padding lets sel index the valid vector safely even when sel >= CH.
    assign valid_pad_c = NPAD'(in_valid);
    assign sel_ok_c    = (32'(sel) < CH);

    mdr_result_arbiter_rr_grant #(
        .CH (CH)
    ) u_rr_grant (
        .valid_i (in_valid),
        .last_i  (last_q),
        .grant_c (rr_grant_c),
        .found_c (rr_found_c)
    );

    always_comb begin
        cap_c   = (state_q == IDLE) || out_ready;
        grant_c = '0;
        found_c = 1'b0;
        if (mode == MODE_RR) begin
            grant_c = rr_grant_c;
            found_c = rr_found_c;
        end else if (sel_ok_c) begin
            grant_c = sel;
            found_c = valid_pad_c[sel];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = !rst && cap_c && found_c && (grant_c == SW'(i));
        end
    end

    // FSM, output slot, round-robin pointer and select-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_src_q  <= '0;
            last_q     <= SW'(CH - 1);
            err_q      <= 1'b0;
        end else begin
            err_q <= cap_c && (mode == MODE_FIXED) && !sel_ok_c;
            if (cap_c) begin
                if (found_c) begin
                    out_data_q <= ch_data[grant_c];
                    out_src_q  <= grant_c;
                    last_q     <= grant_c;
                    state_q    <= HOLD;
                end else begin
                    state_q    <= IDLE;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = (state_q == HOLD);
    assign err_sel   = err_q;

endmodule

// File: tb/tb_mdr_result_arbiter.sv
// Randomised and directed check of mdr_result_arbiter against a behavioural model.
module tb_mdr_result_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic        err_sel;

    int total = 0;
    int bad   = 0;

    // Model: one result slot, a round-robin pointer and the last error flag.
    bit          m_valid;
    logic [3:0]  m_data;
    int          m_src;
    int          m_last;
    bit          m_err;
    logic [2:0]  seen_ready;

    mdr_result_arbiter #(.N(4), .CH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_valid = 1'b0;
        m_data  = 4'h0;
        m_src   = 0;
        m_last  = 2;
        m_err   = 1'b0;
    endtask

    function automatic void model_grant(output bit f, output int g);
        f = 1'b0;
        g = 0;
        if (mode == 1'b0) begin
            if (sel < 2'd3 && in_valid[sel]) begin
                f = 1'b1;
                g = int'(sel);
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (!f && in_valid[c[1:0]]) begin
                    f = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_src",   32'(out_src),   32'(m_src));
        chk("err_sel",   32'(err_sel),   32'(m_err));
    endtask

    // One clock: drive, check in_ready before the edge, advance model, check outputs.
    task automatic step(input logic [2:0] v, input logic [11:0] d, input logic md,
                        input logic [1:0] s, input logic rdy);
        bit         f;
        int         g;
        bit         cap;
        logic [2:0] exp_rdy;
        in_valid  = v;
        in_data   = d;
        mode      = md;
        sel       = s;
        out_ready = rdy;
        #1;
        cap = !m_valid || rdy;
        model_grant(f, g);
        exp_rdy = (cap && f) ? 3'(1 << g) : 3'b000;
        seen_ready = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        m_err = cap && (md == 1'b0) && (s >= 2'd3);
        if (cap) begin
            if (f) begin
                m_valid = 1'b1;
                m_data  = d[g*4 +: 4];
                m_src   = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs();
    endtask

    // Reset asserted between edges; effects must be immediate.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 3'b000;
        in_data   = 12'h000;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_out_src",   32'(out_src),   32'd0);
        chk("reset_err_sel",   32'(err_sel),   32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;

        // Fixed select of ch1.
        step(3'b010, 12'h0A0, 1'b0, 2'd1, 1'b1);
        chk("fix_in_ready", 32'(seen_ready), 32'h2);
        chk("fix_valid", 32'(out_valid), 32'd1);
        chk("fix_data",  32'(out_data),  32'hA);
        chk("fix_src",   32'(out_src),   32'd1);

        // Round-robin from reset: 0,1,2,0 back to back.
        mid_reset();
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 12'h321, 1'b1, 2'd0, 1'b1);
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_src",   32'(out_src),   32'(i % 3));
            chk("rr_data",  32'(out_data),  32'((i % 3) + 1));
        end

        // Hold under backpressure, then load ch2.
        step(3'b001, 12'h005, 1'b0, 2'd0, 1'b1);
        chk("hold_load", 32'(out_data), 32'h5);
        for (int i = 0; i < 4; i++) begin
            step(3'b100, 12'h700, 1'b1, 2'd0, 1'b0);
            chk("hold_ready", 32'(seen_ready), 32'h0);
            chk("hold_data",  32'(out_data),   32'h5);
            chk("hold_valid", 32'(out_valid),  32'd1);
        end
        step(3'b100, 12'h700, 1'b1, 2'd0, 1'b1);
        chk("release_ready", 32'(seen_ready), 32'h4);
        chk("release_data",  32'(out_data),   32'h7);
        chk("release_src",   32'(out_src),    32'd2);

        // Out-of-range select.
        step(3'b000, 12'h000, 1'b0, 2'd0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 12'h321, 1'b0, 2'd3, 1'b1);
            chk("badsel_ready", 32'(seen_ready), 32'h0);
            chk("badsel_err",   32'(err_sel),    32'd1);
            chk("badsel_valid", 32'(out_valid),  32'd0);
        end
        step(3'b000, 12'h000, 1'b0, 2'd0, 1'b1);
        chk("badsel_clear", 32'(err_sel), 32'd0);

        // Reset mid-HOLD, then round-robin restarts at ch0.
        step(3'b001, 12'h009, 1'b1, 2'd0, 1'b0);
        chk("pre_rst_data", 32'(out_data), 32'h9);
        in_valid  = 3'b111;
        out_ready = 1'b1;
        mid_reset();
        step(3'b111, 12'h321, 1'b1, 2'd0, 1'b1);
        chk("post_rst_ready", 32'(seen_ready), 32'h1);
        chk("post_rst_src",   32'(out_src),    32'd0);

        // Random traffic with occasional asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            step(3'($urandom_range(0, 7)), 12'($urandom), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
